order_book_responder: RTL and testbench

- Slave end of the parser→order-book command handshake.
- Accepts one command at a time on master_valid with a 12-bit one-hot stock_activate and order_id, quantity and price.
- Applies the command to a per-stock order table (4 stocks × DEPTH entries) and answers with a one-cycle slave_ready pulse plus a status code.
- Sits between the message parser and the downstream book/strategy logic, and exports per-stock occupancy.

---
 rtl/order_book_responder_if.sv | 30 +++
 rtl/order_book_responder.sv | 243 ++++++++++++++++++++++++
 tb/tb_order_book_responder.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/order_book_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : order_book_responder_if                                   |
// | Purpose  : Parser -> order-book command handshake bundle.            |
// |            The master drives a command and holds master_valid until  |
// |            it sees slave_ready; the slave answers with a status.     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface order_book_responder_if;
  logic        master_valid;
  logic [11:0] stock_activate;
  logic [31:0] in_order_id;
  logic [31:0] in_quantity;
  logic [63:0] in_price;
  logic        slave_ready;
  logic [2:0]  resp_status;
  logic [31:0] resp_order_id;
  logic [1:0]  resp_stock;

  modport master (
    output master_valid, stock_activate, in_order_id, in_quantity, in_price,
    input  slave_ready, resp_status, resp_order_id, resp_stock
  );

  modport slave (
    input  master_valid, stock_activate, in_order_id, in_quantity, in_price,
    output slave_ready, resp_status, resp_order_id, resp_stock
  );
endinterface
`default_nettype wire

// File: rtl/order_book_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : order_book_responder                                      |
// | Purpose  : Slave end of the parser command handshake. Applies ADD /  |
// |            DELETE / DECREASE to a 4-stock x DEPTH order table using  |
// |            a fixed-latency linear scan, then pulses slave_ready with |
// |            a status code. Exports per-stock occupancy.               |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module order_book_responder #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  wire                     clk,
  input  wire                     resetn,
  order_book_responder_if.slave   bus,
  output logic [4*CNT_W-1:0]      occupancy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_SCAN = 3'd1;
  localparam logic [2:0] c_EXEC = 3'd2;
  localparam logic [2:0] c_RESP = 3'd3;
  localparam logic [2:0] c_HOLD = 3'd4;

  localparam logic [1:0] c_OP_ADD = 2'd0;
  localparam logic [1:0] c_OP_DEL = 2'd1;
  localparam logic [1:0] c_OP_DEC = 2'd2;

  localparam logic [2:0] c_ST_OK        = 3'd0;
  localparam logic [2:0] c_ST_FULL      = 3'd1;
  localparam logic [2:0] c_ST_DUP       = 3'd2;
  localparam logic [2:0] c_ST_NOT_FOUND = 3'd3;
  localparam logic [2:0] c_ST_BAD_CMD   = 3'd4;
  localparam logic [2:0] c_ST_REMOVED   = 3'd5;

  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(DEPTH - 1);

  // FSM state
  logic [2:0] r_state;
  logic [2:0] w_next;

  // FSM-derived strobes
  logic w_capture;
  logic w_scan;
  logic w_exec;

  // Captured command
  logic [1:0]  r_stock;
  logic [1:0]  r_op;
  logic        r_bad;
  logic [31:0] r_cmd_id;
  logic [31:0] r_cmd_qty;
  logic [63:0] r_cmd_price;

  // Scan bookkeeping
  logic [IDX_W-1:0] r_idx;
  logic             r_free_found;
  logic [IDX_W-1:0] r_free_idx;
  logic             r_match_found;
  logic [IDX_W-1:0] r_match_idx;

  // Order tables
  logic        r_valid [4][DEPTH];
  logic [31:0] r_id    [4][DEPTH];
  logic [31:0] r_qty   [4][DEPTH];
  logic [63:0] r_price [4][DEPTH];
  logic [CNT_W-1:0] r_occ [4];

  // Registered response
  logic        r_ready;
  logic [2:0]  r_status;
  logic [31:0] r_resp_id;
  logic [1:0]  r_resp_stock;

  // Command decode
  logic       w_onehot;
  logic [1:0] w_dec_stock;
  logic [1:0] w_dec_op;

  // Decode the one-hot select into stock index and operation; bit 11 is stock0 ADD
  always_comb begin
    w_onehot    = (bus.stock_activate != 12'd0) &&
                  ((bus.stock_activate & (bus.stock_activate - 12'd1)) == 12'd0);
    w_dec_stock = 2'd0;
    w_dec_op    = c_OP_ADD;
    for (int s = 0; s < 4; s++) begin
      if (bus.stock_activate[11 - 3*s]) begin
        w_dec_stock = 2'(s);
        w_dec_op    = c_OP_ADD;
      end
      if (bus.stock_activate[10 - 3*s]) begin
        w_dec_stock = 2'(s);
        w_dec_op    = c_OP_DEL;
      end
      if (bus.stock_activate[9 - 3*s]) begin
        w_dec_stock = 2'(s);
        w_dec_op    = c_OP_DEC;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= c_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic; the scan always runs the full table for fixed latency
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: if (bus.master_valid) w_next = w_onehot ? c_SCAN : c_EXEC;
      c_SCAN: if (r_idx == c_LAST_IDX) w_next = c_EXEC;
      c_EXEC: w_next = c_RESP;
      c_RESP: w_next = bus.master_valid ? c_HOLD : c_IDLE;
      c_HOLD: if (!bus.master_valid) w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  // Output decode: per-state strobes that steer the datapath
  always_comb begin
    w_capture = (r_state == c_IDLE) && bus.master_valid;
    w_scan    = (r_state == c_SCAN);
    w_exec    = (r_state == c_EXEC);
  end

  // Datapath: capture, scan one entry per cycle, apply command, register response
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int s = 0; s < 4; s++) begin
        r_occ[s] <= '0;
        for (int e = 0; e < DEPTH; e++) r_valid[s][e] <= 1'b0;
      end
      r_ready       <= 1'b0;
      r_status      <= c_ST_OK;
      r_resp_id     <= '0;
      r_resp_stock  <= '0;
      r_idx         <= '0;
      r_free_found  <= 1'b0;
      r_free_idx    <= '0;
      r_match_found <= 1'b0;
      r_match_idx   <= '0;
      r_stock       <= '0;
      r_op          <= c_OP_ADD;
      r_bad         <= 1'b0;
      r_cmd_id      <= '0;
      r_cmd_qty     <= '0;
      r_cmd_price   <= '0;
    end else begin
      r_ready <= 1'b0;

      if (w_capture) begin
        r_stock       <= w_dec_stock;
        r_op          <= w_dec_op;
        r_bad         <= !w_onehot;
        r_cmd_id      <= bus.in_order_id;
        r_cmd_qty     <= bus.in_quantity;
        r_cmd_price   <= bus.in_price;
        r_idx         <= '0;
        r_free_found  <= 1'b0;
        r_match_found <= 1'b0;
      end

      if (w_scan) begin
        if (!r_valid[r_stock][r_idx] && !r_free_found) begin
          r_free_found <= 1'b1;
          r_free_idx   <= r_idx;
        end
        if (r_valid[r_stock][r_idx] && (r_id[r_stock][r_idx] == r_cmd_id)) begin
          r_match_found <= 1'b1;
          r_match_idx   <= r_idx;
        end
        r_idx <= r_idx + 1'b1;
      end

      if (w_exec) begin
        r_ready      <= 1'b1;
        r_resp_id    <= r_cmd_id;
        r_resp_stock <= r_bad ? 2'd0 : r_stock;
        if (r_bad) begin
          r_status <= c_ST_BAD_CMD;
        end else begin
          case (r_op)
            c_OP_ADD: begin
              if (r_match_found) begin
                r_status <= c_ST_DUP;
              end else if (!r_free_found) begin
                r_status <= c_ST_FULL;
              end else begin
                r_valid[r_stock][r_free_idx] <= 1'b1;
                r_id[r_stock][r_free_idx]    <= r_cmd_id;
                r_qty[r_stock][r_free_idx]   <= r_cmd_qty;
                r_price[r_stock][r_free_idx] <= r_cmd_price;
                r_occ[r_stock]               <= r_occ[r_stock] + 1'b1;
                r_status                     <= c_ST_OK;
              end
            end
            c_OP_DEL: begin
              if (r_match_found) begin
                r_valid[r_stock][r_match_idx] <= 1'b0;
                r_occ[r_stock]                <= r_occ[r_stock] - 1'b1;
                r_status                      <= c_ST_OK;
              end else begin
                r_status <= c_ST_NOT_FOUND;
              end
            end
            default: begin
              // A zero decrement is a no-op even when the stored quantity is zero
              if (!r_match_found) begin
                r_status <= c_ST_NOT_FOUND;
              end else if (r_cmd_qty == 32'd0) begin
                r_status <= c_ST_OK;
              end else if (r_cmd_qty >= r_qty[r_stock][r_match_idx]) begin
                r_valid[r_stock][r_match_idx] <= 1'b0;
                r_occ[r_stock]                <= r_occ[r_stock] - 1'b1;
                r_status                      <= c_ST_REMOVED;
              end else begin
                r_qty[r_stock][r_match_idx] <= r_qty[r_stock][r_match_idx] - r_cmd_qty;
                r_status                    <= c_ST_OK;
              end
            end
          endcase
        end
      end
    end
  end

  // Drive the bus and pack occupancy counters, stock0 in the LSBs
  always_comb begin
    bus.slave_ready   = r_ready;
    bus.resp_status   = r_status;
    bus.resp_order_id = r_resp_id;
    bus.resp_stock    = r_resp_stock;
    occupancy         = '0;
    for (int s = 0; s < 4; s++) occupancy[s*CNT_W +: CNT_W] = r_occ[s];
  end

endmodule
`default_nettype wire

// File: tb/tb_order_book_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_order_book_responder                                   |
// | Purpose  : Directed self-checking bench for order_book_responder.    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_order_book_responder;

  logic        clk;
  logic        resetn;
  logic [15:0] occupancy;
  int          n_checks;
  int          n_errors;

  order_book_responder_if bus_if ();

  order_book_responder #(.DEPTH(8), .CNT_W(4)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus_if),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one command, wait for the pulse, check latency and response,
  // optionally keep master_valid high for 'hold' extra cycles.
  task automatic send(input logic [11:0] sa, input logic [31:0] id, input logic [31:0] qty,
                      input logic [63:0] pr, input logic [2:0] st, input logic [1:0] stk,
                      input int lat, input int hold, input logic [15:0] occ_exp);
    int n;
    bit seen;
    @(negedge clk);
    bus_if.stock_activate = sa;
    bus_if.in_order_id    = id;
    bus_if.in_quantity    = qty;
    bus_if.in_price       = pr;
    bus_if.master_valid   = 1'b1;
    @(posedge clk);
    // Scramble inputs after capture: the captured command must be used
    #2;
    bus_if.in_order_id = ~id;
    bus_if.in_quantity = 32'hDEAD_BEEF;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (bus_if.slave_ready) seen = 1'b1;
    end
    check("ready_seen", 64'(seen), 64'd1);
    check("latency", 64'(n), 64'(lat));
    check("status", 64'(bus_if.resp_status), 64'(st));
    check("resp_id", 64'(bus_if.resp_order_id), 64'(id));
    check("resp_stock", 64'(bus_if.resp_stock), 64'(stk));
    check("occupancy", 64'(occupancy), 64'(occ_exp));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_no_pulse", 64'(bus_if.slave_ready), 64'd0);
      check("hold_occ", 64'(occupancy), 64'(occ_exp));
    end
    @(negedge clk);
    bus_if.master_valid = 1'b0;
    @(posedge clk); #1;
    check("pulse_end", 64'(bus_if.slave_ready), 64'd0);
    check("resp_held", 64'(bus_if.resp_status), 64'(st));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int pulses;
    n_checks = 0;
    n_errors = 0;
    resetn                = 1'b0;
    bus_if.master_valid   = 1'b0;
    bus_if.stock_activate = 12'h000;
    bus_if.in_order_id    = 32'd0;
    bus_if.in_quantity    = 32'd0;
    bus_if.in_price       = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(bus_if.slave_ready), 64'd0);
    check("rst_status", 64'(bus_if.resp_status), 64'd0);
    check("rst_id", 64'(bus_if.resp_order_id), 64'd0);
    check("rst_stock", 64'(bus_if.resp_stock), 64'd0);
    check("rst_occ", 64'(occupancy), 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    // ADD stock1, then duplicate
    send(12'h100, 32'h11, 32'd100, 64'h64, 3'd0, 2'd1, 9, 0, 16'h0010);
    send(12'h100, 32'h11, 32'd100, 64'h64, 3'd2, 2'd1, 9, 0, 16'h0010);

    // Fill stock0, then overflow
    for (int k = 1; k <= 8; k++)
      send(12'h800, 32'(k), 32'd10, 64'(k), 3'd0, 2'd0, 9, 0, 16'h0010 + 16'(k));
    send(12'h800, 32'd9, 32'd10, 64'd9, 3'd1, 2'd0, 9, 0, 16'h0018);

    // DECREASE stock1: partial, exact removal, then not found
    send(12'h040, 32'h11, 32'd30, 64'd0, 3'd0, 2'd1, 9, 0, 16'h0018);
    send(12'h040, 32'h11, 32'd70, 64'd0, 3'd5, 2'd1, 9, 0, 16'h0008);
    send(12'h040, 32'h11, 32'd1,  64'd0, 3'd3, 2'd1, 9, 0, 16'h0008);

    // DELETE on empty stock3, then malformed selects
    send(12'h002, 32'h55, 32'd0, 64'd0, 3'd3, 2'd3, 9, 0, 16'h0008);
    send(12'h000, 32'h66, 32'd0, 64'd0, 3'd4, 2'd0, 1, 0, 16'h0008);
    send(12'h900, 32'h67, 32'd0, 64'd0, 3'd4, 2'd0, 1, 0, 16'h0008);

    // DELETE hit on stock0; reused id on stock3; zero decrement; removal
    send(12'h400, 32'd8,  32'd0, 64'd0, 3'd0, 2'd0, 9, 0, 16'h0007);
    send(12'h004, 32'h11, 32'd5, 64'h5, 3'd0, 2'd3, 9, 0, 16'h1007);
    send(12'h001, 32'h11, 32'd0, 64'd0, 3'd0, 2'd3, 9, 0, 16'h1007);
    send(12'h001, 32'h11, 32'd5, 64'd0, 3'd5, 2'd3, 9, 0, 16'h0007);

    // Held master_valid: single pulse, single write; next command is fresh
    send(12'h020, 32'h77, 32'd3, 64'd7, 3'd0, 2'd2, 9, 5, 16'h0107);
    send(12'h020, 32'h77, 32'd3, 64'd7, 3'd2, 2'd2, 9, 0, 16'h0107);

    // Reset during SCAN aborts the command and clears all tables
    @(negedge clk);
    bus_if.stock_activate = 12'h020;
    bus_if.in_order_id    = 32'h99;
    bus_if.in_quantity    = 32'd1;
    bus_if.master_valid   = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn              = 1'b0;
    bus_if.master_valid = 1'b0;
    @(posedge clk); #1;
    check("midrst_ready", 64'(bus_if.slave_ready), 64'd0);
    check("midrst_occ", 64'(occupancy), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (bus_if.slave_ready) pulses++;
    end
    check("midrst_no_pulse", 64'(pulses), 64'd0);
    send(12'h800, 32'd1, 32'd4, 64'd1, 3'd0, 2'd0, 9, 0, 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
